// File: rtl/aud_i2s_codec_tx_if.sv
// aud_i2s_codec_tx_if: stereo sample pair valid/ready bus
//   left/right  two's complement sample pair
//   valid       pair valid (driven by master)
//   ready       receiver holding buffer empty (driven by slave)
interface aud_i2s_codec_tx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] left;
  logic [DATA_W-1:0] right;
  logic valid;
  logic ready;
  modport master(output left, right, valid, input ready);
  modport slave(input left, right, valid, output ready);
endinterface

// File: rtl/aud_i2s_codec_tx.sv
// aud_i2s_codec_tx: codec-side I2S master transmitter for 16-bit stereo sample pairs
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_en             run enable, sampled only at frame boundaries
//   smp              sample pair valid/ready bus, 1-deep holding buffer
//   o_AUD_BCLK       bit clock, f(i_clk)/(2*HALF_DIV)
//   o_AUD_ADCLRCK    word select, 0 = left slot, 1 = right slot
//   o_AUD_ADCDAT     serial data, MSB first, one BCLK after LRCK change
//   o_underrun       1-cycle pulse when a frame starts with an empty buffer
module aud_i2s_codec_tx #(
  parameter int DATA_W = 16,
  parameter int SLOT_BITS = 32,
  parameter int HALF_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  aud_i2s_codec_tx_if.slave smp,
  output logic o_AUD_BCLK,
  output logic o_AUD_ADCLRCK,
  output logic o_AUD_ADCDAT,
  output logic o_underrun
);
  localparam int CW = $clog2(2 * SLOT_BITS);
  localparam int DVW = $clog2(HALF_DIV + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t st_q, st_d;
  logic [DVW-1:0] div_q, div_d;
  logic [CW-1:0] bit_q, bit_d, bit_n, k;
  logic bclk_q, bclk_d, lrck_q, lrck_d, dat_q, dat_d, und_q, und_d, full_q, full_d;
  logic [DATA_W-1:0] bl_q, bl_d, br_q, br_d, sl_q, sl_d, sr_q, sr_d, sh;
  logic run, wrap, fall, fstart, load, accept;
  always_comb begin
    run = st_q == RUN;
    wrap = run && div_q == DVW'(HALF_DIV - 1);
    fall = wrap && bclk_q;
    bit_n = bit_q == CW'(2 * SLOT_BITS - 1) ? '0 : bit_q + CW'(1);
    // IDLE->RUN entry and the bitcnt wrap are both frame starts; i_en decides run or stop
    fstart = run ? fall && bit_n == '0 : i_en;
    load = fstart && i_en;
    accept = smp.valid && !full_q;
    k = bit_n >= CW'(SLOT_BITS) ? bit_n - CW'(SLOT_BITS) : bit_n;
    // slot bit k (1..DATA_W) lands in the MSB position after shifting by k-1
    sh = (bit_n >= CW'(SLOT_BITS) ? sr_q : sl_q) << (k - CW'(1));
    st_d = fstart ? (i_en ? RUN : IDLE) : st_q;
    div_d = (wrap || !run) ? '0 : div_q + DVW'(1);
    bclk_d = run && (bclk_q ^ wrap);
    bit_d = !run ? '0 : fall ? bit_n : bit_q;
    lrck_d = run && (fall ? bit_n >= CW'(SLOT_BITS) : lrck_q);
    dat_d = run && (fall ? (k != '0 && k <= CW'(DATA_W) && sh[DATA_W-1]) : dat_q);
    sl_d = load ? (full_q ? bl_q : '0) : sl_q;
    sr_d = load ? (full_q ? br_q : '0) : sr_q;
    bl_d = accept ? smp.left : bl_q;
    br_d = accept ? smp.right : br_q;
    full_d = accept || (full_q && !load);
    und_d = load && !full_q;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      st_q <= IDLE;
      div_q <= '0;
      bit_q <= '0;
      bclk_q <= 1'b0;
      lrck_q <= 1'b0;
      dat_q <= 1'b0;
      und_q <= 1'b0;
      full_q <= 1'b0;
      bl_q <= '0;
      br_q <= '0;
      sl_q <= '0;
      sr_q <= '0;
    end else begin
      st_q <= st_d;
      div_q <= div_d;
      bit_q <= bit_d;
      bclk_q <= bclk_d;
      lrck_q <= lrck_d;
      dat_q <= dat_d;
      und_q <= und_d;
      full_q <= full_d;
      bl_q <= bl_d;
      br_q <= br_d;
      sl_q <= sl_d;
      sr_q <= sr_d;
    end
  end
  assign smp.ready = !full_q;
  assign o_AUD_BCLK = bclk_q;
  assign o_AUD_ADCLRCK = lrck_q;
  assign o_AUD_ADCDAT = dat_q;
  assign o_underrun = und_q;
endmodule

// File: tb/tb_aud_i2s_codec_tx.sv
// tb_aud_i2s_codec_tx: randomized bench with I2S receiver and frame-level reference model
module tb_aud_i2s_codec_tx;
  localparam int HD = 2;
  typedef struct {
    int t;
    logic [31:0] d;
  } acc_t;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic bclk, lrck, dat, und;
  int cyc = 0, checks = 0, failures = 0;
  int frames = 0, fs_cnt = 0, fs_last = 0, fs_prev = 0, bclk_bad = 0, rx_gen = 0;
  acc_t acc_q[$];
  aud_i2s_codec_tx_if #(.DATA_W(16)) bus();
  aud_i2s_codec_tx #(.DATA_W(16), .SLOT_BITS(32), .HALF_DIV(HD)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_en(en),
    .smp(bus),
    .o_AUD_BCLK(bclk),
    .o_AUD_ADCLRCK(lrck),
    .o_AUD_ADCDAT(dat),
    .o_underrun(und)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // I2S receiver: one 32-bit word per slot, bit j = j-th BCLK rise after an LRCK change.
  // Expected slot word is {0, sample, 15 zeros}; the pair sent in a frame is the oldest
  // accepted pair whose accept edge precedes that frame's start edge, else silence.
  task automatic rx_mon();
    logic pb = 1'b0, pl = 1'b1, sil;
    logic [31:0] w = '0, lw = '0, exp;
    int j = 0, gen = 0, last_rise = 0, fs = 0, spur, hit;
    int uq[$];
    acc_t e;
    forever begin
      @(negedge clk);
      if (gen != rx_gen) begin
        gen = rx_gen;
        pl = 1'b1;
        pb = bclk;
        j = 0;
        w = '0;
        uq.delete();
      end
      if (und) uq.push_back(cyc);
      if (bclk && !pb) begin
        if (lrck != pl) begin
          j = 0;
          if (!lrck) begin
            fs = cyc - HD;
            fs_prev = fs_last;
            fs_last = fs;
            fs_cnt++;
          end
        end else begin
          j++;
          if (cyc - last_rise != 2 * HD) bclk_bad++;
        end
        last_rise = cyc;
        w = {w[30:0], dat};
        pl = lrck;
        if (j == 31 && !lrck) lw = w;
        if (j == 31 && lrck) begin
          exp = '0;
          sil = 1'b1;
          if (acc_q.size() > 0 && acc_q[0].t < fs) begin
            e = acc_q.pop_front();
            exp = e.d;
            sil = 1'b0;
          end
          check("left_word", 64'(lw), 64'({1'b0, exp[31:16], 15'b0}));
          check("right_word", 64'(w), 64'({1'b0, exp[15:0], 15'b0}));
          hit = 0;
          spur = 0;
          while (uq.size() > 0 && uq[0] <= fs) begin
            if (uq[0] == fs) hit = 1;
            else spur++;
            void'(uq.pop_front());
          end
          check("underrun", 64'(spur * 2 + hit), 64'(sil));
          frames++;
        end
      end
      pb = bclk;
    end
  endtask
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int n = 0;
    bus.left = l;
    bus.right = r;
    bus.valid = 1'b1;
    while (!bus.ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check("send_timeout", 64'(0), 64'(1));
      bus.valid = 1'b0;
      return;
    end
    acc_q.push_back('{cyc + 1, {l, r}});
    @(negedge clk);
    bus.valid = 1'b0;
    bus.left = 16'($urandom);
    bus.right = 16'($urandom);
  endtask
  task automatic wait_frames(input int n);
    int tgt = frames + n, t = 0;
    while (frames < tgt && t < 300 * n) begin
      @(negedge clk);
      t++;
    end
    check("frame_wait", 64'(frames >= tgt), 64'(1));
  endtask
  task automatic drain();
    int t = 0;
    while (acc_q.size() > 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(acc_q.size()), 64'(0));
  endtask
  initial begin
    int bad, fr0, t;
    bus.valid = 1'b0;
    bus.left = '0;
    bus.right = '0;
    fork
      rx_mon();
    join_none
    repeat (3) @(negedge clk);
    check("reset", 64'({bclk, lrck, dat, und, bus.ready}), 64'(5'b00001));
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({bclk, lrck, dat, und, bus.ready} !== 5'b00001) bad++;
    end
    check("idle_outputs", 64'(bad), 64'(0));
    send(16'hA5C3, 16'h8001);
    en = 1'b1;
    wait_frames(2);
    check("lrck_period", 64'(fs_last - fs_prev), 64'(256));
    wait_frames(3);
    for (int i = 0; i < 8; i++) send(16'(i), ~16'(i));
    drain();
    wait_frames(1);
    send(16'h1234, 16'hFEDC);
    send(16'h0F0F, 16'h7001);
    repeat (2) @(negedge clk);
    while (cyc < fs_last + 42) @(negedge clk);
    en = 1'b0;
    while (cyc < fs_last + 270) @(negedge clk);
    fr0 = frames;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({bclk, lrck, dat, und, bus.ready} !== 5'b00000) bad++;
    end
    check("idle_hold", 64'(bad), 64'(0));
    check("no_frames_idle", 64'(frames), 64'(fr0));
    en = 1'b1;
    wait_frames(2);
    check("buffered_sent", 64'(acc_q.size()), 64'(0));
    send(16'hCAFE, 16'hBEEF);
    send(16'h5555, 16'hAAAA);
    t = 0;
    while (!lrck && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("right_slot_wait", 64'(lrck), 64'(1));
    repeat (20) @(negedge clk);
    rx_gen++;
    acc_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset", 64'({bclk, lrck, dat, und, bus.ready}), 64'(5'b00001));
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 300)) @(negedge clk);
      send(16'($urandom), 16'($urandom));
    end
    drain();
    wait_frames(1);
    check("bclk_period", 64'(bclk_bad), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
